muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide unit producing HI/LO.
// One shift-add (multiply) or restoring-subtract (divide) step per clock,
// WIDTH steps per operation. Signed operations run on magnitudes and the
// signs are applied when the last step completes.
// Optional feature macro: MULDIV_ZERO_BYPASS_EN (b==0 finishes after one step).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   md_q, md_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_sr;
    logic [2*WIDTH-1:0] product;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // One iteration of the shared datapath: acc holds the running upper half
    // (multiply) or partial remainder (divide); sr holds multiplier/quotient bits.
    always_comb begin
        add_sum   = {1'b0, acc_q} + (sr_q[0] ? {1'b0, md_q} : '0);
        rem_shift = {acc_q, sr_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, md_q};
        step_acc  = '0;
        step_sr   = '0;
        if (is_div_q) begin
            if (!rem_diff[WIDTH]) begin
                step_acc = rem_diff[WIDTH-1:0];
                step_sr  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = rem_shift[WIDTH-1:0];
                step_sr  = {sr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = add_sum[WIDTH:1];
            step_sr  = {add_sum[0], sr_q[WIDTH-1:1]};
        end
        product = {step_acc, step_sr};
        if (neg_res_q) begin
            product = -product;
        end
    end

    // Operand sign handling at request time: signed ops store magnitudes.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    // Next-state and result logic: accept in IDLE, iterate in CALC, publish on the last step.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        a_raw_d   = a_raw_q;
        md_d      = md_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d   = CALC;
                    is_div_d  = op[1];
                    zero_d    = (b == '0);
                    a_raw_d   = a;
                    md_d      = op[1] ? mag_b : mag_a;
                    sr_d      = op[1] ? mag_a : mag_b;
                    acc_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
`ifdef MULDIV_ZERO_BYPASS_EN
                    cnt_d     = (b == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
`else
                    cnt_d     = CNT_W'(WIDTH);
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    sr_d  = step_sr;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dbz_d   = is_div_q & zero_q;
                        if (is_div_q) begin
                            if (zero_q) begin
                                hi_d = a_raw_q;
                                lo_d = '1;
                            end else begin
                                hi_d = neg_rem_q ? -step_acc : step_acc;
                                lo_d = neg_res_q ? -step_sr : step_sr;
                            end
                        end else begin
                            hi_d = product[2*WIDTH-1:WIDTH];
                            lo_d = product[WIDTH-1:0];
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            a_raw_q   <= '0;
            md_q      <= '0;
            sr_q      <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            a_raw_q   <= a_raw_d;
            md_q      <= md_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed table, randomized ops against an arithmetic
// reference model, and hand-written flush/reset/busy sequences for muldiv_seq.
module tb_muldiv_seq;

    localparam int WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } result_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_vectors;
    int n_miscompares;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model straight from the arithmetic definition of each opcode.
    function automatic result_t refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        result_t     r;
        longint      sx;
        longint      sy;
        longint      q;
        longint      rm;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.hi = '0;
        r.lo = '0;
        r.dbz = 1'b0;
        case (o)
            OP_MULT: begin
                p = 64'(sx * sy);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    r.hi = x;
                    r.lo = 32'hFFFF_FFFF;
                    r.dbz = 1'b1;
                end else if (o == OP_DIV) begin
                    q = sx / sy;
                    rm = sx % sy;
                    r.lo = 32'(q);
                    r.hi = 32'(rm);
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
        endcase
        return r;
    endfunction

    function automatic int expLatency(input logic [31:0] y);
`ifdef MULDIV_ZERO_BYPASS_EN
        return (y == 32'd0) ? 1 : WIDTH;
`else
        if (y == 32'd0) return WIDTH;
        return WIDTH;
`endif
    endfunction

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Presents a request for one clock; returns #1 after the sampling edge (edge 0).
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full operation: request, bounded wait for done, compare latency and results.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input string nm);
        int cyc;
        bit seen;
        bit busy_ok;
        applyStimulus(o, x, y);
        checkOutput({nm, " busy_after_start"}, 64'(busy), 64'(1));
        cyc = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cyc < WIDTH + 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        checkOutput({nm, " done_seen"}, 64'(seen), 64'(1));
        checkOutput({nm, " latency"}, 64'(cyc), 64'(expLatency(y)));
        checkOutput({nm, " busy_held"}, 64'(busy_ok), 64'(1));
        checkOutput({nm, " busy_at_done"}, 64'(busy), 64'(0));
        checkOutput({nm, " hi"}, 64'(hi), 64'(ehi));
        checkOutput({nm, " lo"}, 64'(lo), 64'(elo));
        checkOutput({nm, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
        last_hi = ehi;
        last_lo = elo;
    endtask

    // Counts done pulses over a window to prove nothing completes.
    task automatic expectNoDone(input int ncyc, input string nm);
        int pulses;
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput({nm, " no_done"}, 64'(pulses), 64'(0));
    endtask

    // Main test sequence.
    initial begin
        vec_t    tbl[8];
        result_t exp_r;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int cyc;
        bit seen;

        n_vectors = 0;
        n_miscompares = 0;
        last_hi = '0;
        last_lo = '0;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;

        tbl[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0};
        tbl[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
        tbl[5] = '{OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        tbl[7] = '{OP_MULT,  32'h1234_5678, 32'd0,        32'd0,         32'd0,         1'b0};

        #12;
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset hi", 64'(hi), 64'(0));
        checkOutput("reset lo", 64'(lo), 64'(0));
        checkOutput("reset div_by_zero", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            runOp(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz,
                  $sformatf("tbl%0d", i));
        end

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            exp_r = refModel(ro, ra, rb);
            runOp(ro, ra, rb, exp_r.hi, exp_r.lo, exp_r.dbz, $sformatf("rnd%0d", i));
        end

        $display("[TB] flush during the done cycle");
        runOp(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, "pre_flush");
        flush = 1'b1;
        #1;
        checkOutput("flush_in_done done", 64'(done), 64'(1));
        checkOutput("flush_in_done lo", 64'(lo), 64'(81));
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("done_one_cycle", 64'(done), 64'(0));
        checkOutput("result_held lo", 64'(lo), 64'(81));

        $display("[TB] flush during CALC");
        applyStimulus(OP_MULTU, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("flush_calc busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_calc busy_after", 64'(busy), 64'(0));
        checkOutput("flush_calc done", 64'(done), 64'(0));
        expectNoDone(WIDTH + 4, "flush_calc");
        checkOutput("flush_calc hi", 64'(hi), 64'(last_hi));
        checkOutput("flush_calc lo", 64'(lo), 64'(last_lo));

        $display("[TB] flush overrides start in IDLE");
        start = 1'b1;
        flush = 1'b1;
        op = OP_MULTU;
        a = 32'd2;
        b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush_idle busy", 64'(busy), 64'(0));
        expectNoDone(WIDTH + 3, "flush_idle");
        checkOutput("flush_idle lo", 64'(lo), 64'(last_lo));

        $display("[TB] start while busy is ignored");
        applyStimulus(OP_MULTU, 32'd3, 32'd5);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < WIDTH + 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 4) begin
                start = 1'b1;
                op = OP_DIVU;
                a = 32'd100;
                b = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        checkOutput("busy_start done_seen", 64'(seen), 64'(1));
        checkOutput("busy_start latency", 64'(cyc), 64'(WIDTH));
        checkOutput("busy_start hi", 64'(hi), 64'(0));
        checkOutput("busy_start lo", 64'(lo), 64'(15));
        expectNoDone(WIDTH + 4, "busy_start_not_queued");
        checkOutput("busy_start idle", 64'(busy), 64'(0));

        $display("[TB] reset mid-CALC");
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset busy", 64'(busy), 64'(0));
        checkOutput("mid_reset done", 64'(done), 64'(0));
        checkOutput("mid_reset hi", 64'(hi), 64'(0));
        checkOutput("mid_reset lo", 64'(lo), 64'(0));
        checkOutput("mid_reset div_by_zero", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        expectNoDone(WIDTH + 4, "mid_reset");
        checkOutput("mid_reset lo_after", 64'(lo), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
